// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci sequence generator.
// Holds the FSM state type, the default datapath widths and the add helper
// that the step logic uses.
package fib_pkg;

    // Default data width of the seeds and terms.
    localparam int FIB_WIDTH = 8;

    // Default width of the term count and the term index.
    localparam int FIB_CNT_W = 8;

    // Operand width of the add helper.
    // Data widths from 1 to FIB_MAX_W-1 are supported.
    localparam int FIB_MAX_W = 64;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fib_state_e;

    // Adds two zero-extended operands and returns the full-width result.
    // For a W-bit add, bit [W] of the result is the carry and bits
    // [W-1:0] are the wrapped sum.
    function automatic logic [FIB_MAX_W:0] fib_add(
        input logic [FIB_MAX_W-1:0] i_x,
        input logic [FIB_MAX_W-1:0] i_y
    );
        logic [FIB_MAX_W:0] w_sum;
        w_sum = {1'b0, i_x} + {1'b0, i_y};
        return w_sum;
    endfunction

endpackage

// File: rtl/fib_step.sv
// One Fibonacci step: (a, b) -> (b, a+b), with wrap tracking.
// A term is marked as wrapped if it wrapped itself, or if any term it was
// derived from wrapped. The block is purely combinational.
module fib_step
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_a_ovf,
    input  logic             i_b_ovf,
    output logic [WIDTH-1:0] o_next_a,
    output logic [WIDTH-1:0] o_next_b,
    output logic             o_next_a_ovf,
    output logic             o_next_b_ovf
);

    logic [FIB_MAX_W-1:0] w_a_ext;
    logic [FIB_MAX_W-1:0] w_b_ext;
    logic [FIB_MAX_W:0]   w_full;
    logic                 w_carry;
    logic                 w_unused;

    // Zero-extend both operands to the width of the add helper, then add.
    always_comb begin
        w_a_ext              = '0;
        w_b_ext              = '0;
        w_a_ext[WIDTH-1:0]   = i_a;
        w_b_ext[WIDTH-1:0]   = i_b;
        w_full               = fib_add(w_a_ext, w_b_ext);
        w_carry              = w_full[WIDTH];
    end

    // The bits above the carry are always zero, because the operands are
    // zero-extended.
    assign w_unused = |w_full[FIB_MAX_W:WIDTH+1];

    // Shift the pair forward and propagate the wrap history.
    always_comb begin
        o_next_a     = i_b;
        o_next_b     = w_full[WIDTH-1:0];
        o_next_a_ovf = i_b_ovf;
        o_next_b_ovf = i_a_ovf | i_b_ovf | w_carry;
    end

endmodule

// File: rtl/fib_seq_gen.sv
// Fibonacci sequence generator.
// On start, the block captures two seeds and a last index N. It then streams
// F(0)..F(N) over a valid/ready interface, and pulses done for one cycle
// after the last term is taken. All outputs come straight from registers.
module fib_seq_gen
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH,
    parameter int CNT_W = FIB_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_n_terms,
    input  logic [WIDTH-1:0] i_seed0,
    input  logic [WIDTH-1:0] i_seed1,
    output logic             o_busy,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic [CNT_W-1:0] o_out_index,
    output logic             o_out_ovf,
    output logic             o_done
);

    fib_state_e       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_n;
    logic             r_a_ovf;
    logic             r_b_ovf;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_next_a;
    logic [WIDTH-1:0] w_next_b;
    logic             w_next_a_ovf;
    logic             w_next_b_ovf;
    logic             w_handshake;
    logic             w_last;

    fib_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_a          (r_a),
        .i_b          (r_b),
        .i_a_ovf      (r_a_ovf),
        .i_b_ovf      (r_b_ovf),
        .o_next_a     (w_next_a),
        .o_next_b     (w_next_b),
        .o_next_a_ovf (w_next_a_ovf),
        .o_next_b_ovf (w_next_b_ovf)
    );

    assign w_handshake = r_valid & i_out_ready;
    assign w_last      = (r_count == r_n);

    // Sequencer FSM.
    // This block holds the datapath registers and the registered status
    // outputs. r_valid is high only in RUN, and the index never passes r_n,
    // so the count cannot wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_count <= '0;
            r_n     <= '0;
            r_a_ovf <= 1'b0;
            r_b_ovf <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    // start wins over a simultaneous abort here, because
                    // abort has no effect in IDLE.
                    if (i_start) begin
                        r_state <= ST_RUN;
                        r_a     <= i_seed0;
                        r_b     <= i_seed1;
                        r_n     <= i_n_terms;
                        r_count <= '0;
                        r_a_ovf <= 1'b0;
                        r_b_ovf <= 1'b0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // abort takes priority over a handshake in the same cycle.
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else if (w_handshake) begin
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b1;
                        end else begin
                            r_a     <= w_next_a;
                            r_b     <= w_next_b;
                            r_a_ovf <= w_next_a_ovf;
                            r_b_ovf <= w_next_b_ovf;
                            r_count <= r_count + CNT_W'(1);
                        end
                    end else begin
                        // Backpressure: hold the presented term unchanged.
                        r_state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    // DONE always lasts one cycle, whether or not abort is high.
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_out_valid = r_valid;
    assign o_out_data  = r_a;
    assign o_out_index = r_count;
    assign o_out_ovf   = r_a_ovf;
    assign o_done      = r_done;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Testbench for fib_seq_gen.
// Stimulus tasks push the expected terms into a queue. A monitor pops and
// compares a term on every accepted transfer, and also checks done timing
// and that a stalled term stays stable.
module tb_fib_seq_gen;

    typedef struct {
        logic [7:0] data;
        logic [7:0] idx;
        logic       ovf;
    } term_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort_s;
    logic [7:0] n_terms;
    logic [7:0] seed0;
    logic [7:0] seed1;
    logic       busy;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [7:0] out_index;
    logic       out_ovf;
    logic       done;

    int         checks;
    int         failures;
    int         cyc;
    int         last_pop_cyc;
    int         done_cnt;
    int         ready_mode;
    logic       done_pending;
    logic       held_valid;
    logic [7:0] held_data;
    logic [7:0] held_idx;
    term_t      exp_q[$];

    // Hand-computed terms for seeds 0/1.
    // Only F(14) = 377 mod 256 = 121 has wrapped.
    logic [7:0] fib_tab [0:14] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8,
                                   8'd13, 8'd21, 8'd34, 8'd55, 8'd89, 8'd144,
                                   8'd233, 8'd121};

    fib_seq_gen #(.WIDTH(8), .CNT_W(8)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_abort     (abort_s),
        .i_n_terms   (n_terms),
        .i_seed0     (seed0),
        .i_seed1     (seed1),
        .o_busy      (busy),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_out_index (out_index),
        .o_out_ovf   (out_ovf),
        .o_done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model. It tracks the wrapped term, and separately the true
    // value of the term (saturated far above 2^8). A term is flagged as
    // wrapped exactly when its true value is at least 256.
    task automatic push_model(input int n, input int s0, input int s1);
        longint wa = s0;
        longint wb = s1;
        longint ta = s0;
        longint tb = s1;
        longint tn;
        longint wn;
        term_t  t;
        for (int k = 0; k <= n; k++) begin
            t.data = 8'(wa);
            t.idx  = 8'(k);
            t.ovf  = (ta >= 256);
            exp_q.push_back(t);
            wn = (wa + wb) % 256;
            tn = ta + tb;
            if (tn > 64'd1099511627776) tn = 64'd1099511627776;
            wa = wb; wb = wn;
            ta = tb; tb = tn;
        end
    endtask

    task automatic push_table(input int n);
        term_t t;
        for (int k = 0; k <= n; k++) begin
            t.data = fib_tab[k];
            t.idx  = 8'(k);
            t.ovf  = (k == 14);
            exp_q.push_back(t);
        end
    endtask

    // Issue a start. The expected terms come from the hand table or the model.
    // Afterwards, scramble the inputs to show that they were captured.
    task automatic start_seq(input int n, input int s0, input int s1, input bit use_table);
        @(posedge clk); #2;
        start   = 1'b1;
        n_terms = 8'(n);
        seed0   = 8'(s0);
        seed1   = 8'(s1);
        if (use_table) push_table(n);
        else push_model(n, s0, s1);
        done_pending = 1'b1;
        @(posedge clk); #2;
        start   = 1'b0;
        n_terms = 8'($urandom_range(0, 255));
        seed0   = 8'($urandom_range(0, 255));
        seed1   = 8'($urandom_range(0, 255));
        chk("start_latency_valid", out_valid, 1);
        chk("start_latency_index", out_index, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_pending && n < 4000) begin
            @(negedge clk); #4;
            n++;
        end
        chk("done_timeout", done_pending, 0);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    // Ready driver: always high, random, or always low.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            if (ready_mode == 0) out_ready = 1'b1;
            else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
            else out_ready = 1'b0;
        end
    end

    // Monitor: compare accepted terms, check done timing and stall stability.
    initial begin
        forever begin
            @(negedge clk); #3;
            cyc++;
            if (rst_n) begin
                if (done) begin
                    chk("done_expected", done_pending, 1);
                    chk("done_after_last", cyc - last_pop_cyc, 1);
                    chk("done_not_with_valid", out_valid, 0);
                    done_pending = 1'b0;
                    done_cnt++;
                end
                if (out_valid && held_valid) begin
                    chk("stall_data_stable", out_data, held_data);
                    chk("stall_index_stable", out_index, held_idx);
                end
                if (out_valid && out_ready && !abort_s) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_term", out_index, -1);
                    end else begin
                        term_t e;
                        e = exp_q.pop_front();
                        chk("term_data", out_data, e.data);
                        chk("term_index", out_index, e.idx);
                        chk("term_ovf", out_ovf, e.ovf);
                        last_pop_cyc = cyc;
                    end
                end
                held_valid = out_valid && !out_ready && !abort_s;
                held_data  = out_data;
                held_idx   = out_index;
            end else begin
                held_valid = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dc;
        int found;
        checks = 0; failures = 0; cyc = 0; last_pop_cyc = -10; done_cnt = 0;
        ready_mode = 0; done_pending = 1'b0; held_valid = 1'b0;
        rst_n = 1'b0; start = 1'b0; abort_s = 1'b0;
        n_terms = 8'd0; seed0 = 8'd0; seed1 = 8'd0;
        #12;
        chk("reset_outputs_zero", {busy, out_valid, done, out_ovf, out_data, out_index}, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Seeds 0/1, N=10, no backpressure.
        start_seq(10, 0, 1, 1'b1);
        wait_done();
        // N=14: the wrap appears at F(14).
        start_seq(14, 0, 1, 1'b1);
        wait_done();
        // The N=10 run again, under random backpressure.
        ready_mode = 1;
        start_seq(10, 0, 1, 1'b1);
        wait_done();
        ready_mode = 0;
        // N=0 emits only seed0.
        start_seq(0, 7, 99, 1'b0);
        wait_done();
        // N=1 emits seed0 and seed1.
        start_seq(1, 200, 150, 1'b0);
        wait_done();

        // Randomised sequences, including the maximum N.
        for (int it = 0; it < 8; it++) begin
            ready_mode = int'($urandom_range(0, 1));
            start_seq((it == 3) ? 255 : int'($urandom_range(0, 40)),
                      int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0);
            wait_done();
        end

        // A start pulsed mid-sequence must be ignored.
        ready_mode = 1;
        start_seq(20, 5, 9, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        start = 1'b1; seed0 = 8'd77; seed1 = 8'd88; n_terms = 8'd3;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done();

        // Abort at index 4: no done pulse, then a fresh start.
        start_seq(10, 3, 4, 1'b0);
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            @(negedge clk); #1;
            if (out_valid && out_index == 8'd4) found = 1;
        end
        chk("abort_index_reached", found, 1);
        abort_s = 1'b1;
        dc = done_cnt;
        @(posedge clk); #2;
        abort_s = 1'b0;
        chk("abort_valid_low", out_valid, 0);
        chk("abort_busy_low", busy, 0);
        exp_q.delete();
        done_pending = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("abort_no_done", done_cnt, dc);
        start_seq(12, 1, 1, 1'b0);
        wait_done();

        // Asynchronous reset mid-run.
        start_seq(30, 2, 3, 1'b0);
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs_zero", {busy, out_valid, done, out_ovf, out_data, out_index}, 0);
        exp_q.delete();
        done_pending = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_after_reset", {out_valid, busy, done}, 0);
        end
        ready_mode = 0;
        start_seq(6, 10, 20, 1'b0);
        wait_done();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
